// File: rtl/line_scheduler.sv
// line_scheduler: shares one line_drawer among N_REQ line clients.
// Define LINE_SCHED_PRIORITY_EN for fixed lowest-index-first arbitration.
module line_scheduler #(
   parameter int N_REQ = 2,
   parameter int W     = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_x0,
   input  logic [N_REQ*W-1:0] req_y0,
   input  logic [N_REQ*W-1:0] req_x1,
   input  logic [N_REQ*W-1:0] req_y1,
   input  logic [N_REQ-1:0]   req_color,
   output logic [N_REQ-1:0]   req_done,
   output logic               drv_start,
   output logic [W-1:0]       drv_x0,
   output logic [W-1:0]       drv_y0,
   output logic [W-1:0]       drv_x1,
   output logic [W-1:0]       drv_y1,
   input  logic               drv_finished,
   output logic               pixel_wr,
   output logic               pixel_color,
   output logic               busy
);

   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE,
      START,
      DRAW,
      DONE
   } state_t;

   typedef struct packed {
      logic         color;
      logic [W-1:0] x0;
      logic [W-1:0] y0;
      logic [W-1:0] x1;
      logic [W-1:0] y1;
   } job_t;

   state_t        state;
   state_t        state_nx;
   job_t          job_q;
   job_t          job_in;
   logic [GW-1:0] gnt_q;
   logic [GW-1:0] win;
   logic          win_vld;
   logic          accept;

`ifdef LINE_SCHED_PRIORITY_EN
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            win     = GW'(i);
            win_vld = 1'b1;
         end
      end
   end
`else
   logic [GW-1:0] last_grant;
   logic [GW-1:0] cand;
   int            rr_idx;

   // Scan downward so the smallest offset from last_grant+1 wins.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      cand    = '0;
      rr_idx  = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         rr_idx = int'(last_grant) + 1 + k;
         if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
         cand = GW'(rr_idx);
         if (req_valid[cand]) begin
            win     = cand;
            win_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant <= GW'(N_REQ - 1);
      end else if (accept) begin
         last_grant <= win;
      end
   end
`endif

   // Gated by reset so no acceptance pulse leaks out while held in reset.
   assign accept = (state == IDLE) && win_vld && reset;

   always_comb begin
      job_in.color = req_color[win];
      job_in.x0    = req_x0[int'(win)*W +: W];
      job_in.y0    = req_y0[int'(win)*W +: W];
      job_in.x1    = req_x1[int'(win)*W +: W];
      job_in.y1    = req_y1[int'(win)*W +: W];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         gnt_q <= '0;
         job_q <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            gnt_q <= win;
            job_q <= job_in;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      req_ready = '0;
      req_done  = '0;
      drv_start = 1'b0;
      pixel_wr  = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               req_ready = ONE << win;
               state_nx  = START;
            end
         end
         START: begin
            drv_start = 1'b1;
            state_nx  = DRAW;
         end
         DRAW: begin
            pixel_wr = !drv_finished;
            if (drv_finished) state_nx = DONE;
         end
         DONE: begin
            req_done = ONE << gnt_q;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy        = (state != IDLE);
   assign pixel_color = job_q.color;
   assign drv_x0      = job_q.x0;
   assign drv_y0      = job_q.y0;
   assign drv_x1      = job_q.x1;
   assign drv_y1      = job_q.y1;

endmodule

// File: tb/tb_line_scheduler.sv
// tb_line_scheduler: directed bench for line_scheduler.
// Includes a counting model of the line_drawer finished handshake.
module tb_line_scheduler;

   localparam int N = 2;
   localparam int W = 11;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_x0 = '0;
   logic [N*W-1:0] req_y0 = '0;
   logic [N*W-1:0] req_x1 = '0;
   logic [N*W-1:0] req_y1 = '0;
   logic [N-1:0]   req_color = '0;
   logic [N-1:0]   req_done;
   logic           drv_start;
   logic [W-1:0]   drv_x0, drv_y0, drv_x1, drv_y1;
   logic           drv_finished;
   logic           pixel_wr, pixel_color, busy;

   int vectors = 0;
   int miscompares = 0;

   line_scheduler #(.N_REQ(N), .W(W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x0(req_x0), .req_y0(req_y0),
      .req_x1(req_x1), .req_y1(req_y1),
      .req_color(req_color), .req_done(req_done),
      .drv_start(drv_start),
      .drv_x0(drv_x0), .drv_y0(drv_y0),
      .drv_x1(drv_x1), .drv_y1(drv_y1),
      .drv_finished(drv_finished),
      .pixel_wr(pixel_wr), .pixel_color(pixel_color),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int span(input logic [W-1:0] a, b, c, d);
      int dx, dy;
      dx = (a > c) ? int'(a) - int'(c) : int'(c) - int'(a);
      dy = (b > d) ? int'(b) - int'(d) : int'(d) - int'(b);
      return (dx > dy) ? dx : dy;
   endfunction

   // Drawer model: finished drops after restart, then span+1 pixel cycles.
   int mcnt;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drv_finished <= 1'b1;
         mcnt <= 0;
      end else if (drv_start) begin
         drv_finished <= 1'b0;
         mcnt <= span(drv_x0, drv_y0, drv_x1, drv_y1);
      end else if (!drv_finished) begin
         if (mcnt == 0) drv_finished <= 1'b1;
         else mcnt <= mcnt - 1;
      end
   end

   task automatic set_job(input int i, input int x0, y0, x1, y1,
                          input logic col);
      req_x0[i*W +: W] = W'(x0);
      req_y0[i*W +: W] = W'(y0);
      req_x1[i*W +: W] = W'(x1);
      req_y1[i*W +: W] = W'(y1);
      req_color[i] = col;
   endtask

   task automatic do_reset();
      @(negedge clk);
      req_valid = '0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Observes one job from its START cycle (c=0) to the cycle after DONE.
   task automatic run_job(
      input  int           hook_c,
      input  logic [N-1:0] drop,
      input  logic [N-1:0] hook_v,
      input  logic [W-1:0] hook_x1,
      output int           pix,
      output int           first_pix,
      output int           done_c,
      output logic [N-1:0] done_v,
      output int           nstart,
      output logic         col0,
      output logic [W-1:0] x1_0,
      output logic         x1_chg,
      output logic         early_rdy,
      output logic [N-1:0] rdy_end,
      output logic         busy_end,
      output logic         done_tail
   );
      pix = 0; first_pix = -1; done_c = -1; done_v = '0;
      nstart = 0; col0 = 1'b0; x1_0 = '0; x1_chg = 1'b0;
      early_rdy = 1'b0; rdy_end = '0; busy_end = 1'b1;
      done_tail = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (c == 0) req_valid = req_valid & ~drop;
         if (c == hook_c) begin
            req_valid = req_valid | hook_v;
            req_x1[W +: W] = hook_x1;
         end
         #1;
         if (c == 0) begin
            col0 = pixel_color;
            x1_0 = drv_x1;
         end else if (drv_x1 !== x1_0) begin
            x1_chg = 1'b1;
         end
         if (drv_start) nstart++;
         if (pixel_wr) begin
            pix++;
            if (first_pix < 0) first_pix = c;
         end
         if (done_c >= 0) begin
            rdy_end = req_ready;
            busy_end = busy;
            done_tail = |req_done;
            break;
         end
         if (|req_ready) early_rdy = 1'b1;
         if (|req_done) begin
            done_c = c;
            done_v = req_done;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] got[$], exp[$];
      string nm[$];
      set_job(0, 5, 6, 7, 8, 1'b1);
      set_job(1, 9, 9, 1, 1, 1'b1);
      req_valid = 2'b11;
      #2 reset = 1'b0;
      #1;
      got.push_back(32'(req_ready)); exp.push_back(0); nm.push_back("rst_ready");
      got.push_back(32'(req_done)); exp.push_back(0); nm.push_back("rst_done");
      got.push_back(32'(drv_start)); exp.push_back(0); nm.push_back("rst_start");
      got.push_back(32'(pixel_wr)); exp.push_back(0); nm.push_back("rst_pixwr");
      got.push_back(32'(pixel_color)); exp.push_back(0); nm.push_back("rst_color");
      got.push_back(32'(busy)); exp.push_back(0); nm.push_back("rst_busy");
      got.push_back(32'(drv_x0)); exp.push_back(0); nm.push_back("rst_x0");
      got.push_back(32'(drv_y0)); exp.push_back(0); nm.push_back("rst_y0");
      got.push_back(32'(drv_x1)); exp.push_back(0); nm.push_back("rst_x1");
      got.push_back(32'(drv_y1)); exp.push_back(0); nm.push_back("rst_y1");
      for (int i = 0; i < got.size(); i++) begin
         vectors++;
         if (got[i] !== exp[i]) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm[i], got[i], exp[i]);
         end
      end
      req_valid = '0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_single();
      logic [31:0] got[$], exp[$];
      string nm[$];
      int pix, fp, dc, ns;
      logic [N-1:0] dv, re;
      logic c0, xc, er, be, dt;
      logic [W-1:0] x10;
      do_reset();
      set_job(0, 2, 2, 32, 12, 1'b1);
      req_valid = 2'b01;
      #1;
      got.push_back(32'(req_ready)); exp.push_back(1); nm.push_back("single_ready");
      run_job(-1, 2'b01, 2'b00, '0,
              pix, fp, dc, dv, ns, c0, x10, xc, er, re, be, dt);
      got.push_back(32'(ns)); exp.push_back(1); nm.push_back("single_nstart");
      got.push_back(32'(c0)); exp.push_back(1); nm.push_back("single_color");
      got.push_back(32'(pix)); exp.push_back(31); nm.push_back("single_pixels");
      got.push_back(32'(fp)); exp.push_back(1); nm.push_back("single_first_pix");
      got.push_back(32'(dc)); exp.push_back(33); nm.push_back("single_done_cyc");
      got.push_back(32'(dv)); exp.push_back(1); nm.push_back("single_done_vec");
      got.push_back(32'(dt)); exp.push_back(0); nm.push_back("single_done_1cyc");
      got.push_back(32'(er)); exp.push_back(0); nm.push_back("single_early_rdy");
      got.push_back(32'(be)); exp.push_back(0); nm.push_back("single_busy_end");
      got.push_back(32'(drv_x0)); exp.push_back(2); nm.push_back("single_x0");
      got.push_back(32'(drv_y0)); exp.push_back(2); nm.push_back("single_y0");
      got.push_back(32'(drv_x1)); exp.push_back(32); nm.push_back("single_x1");
      got.push_back(32'(drv_y1)); exp.push_back(12); nm.push_back("single_y1");
      for (int i = 0; i < got.size(); i++) begin
         vectors++;
         if (got[i] !== exp[i]) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm[i], got[i], exp[i]);
         end
      end
   endtask

   task automatic test_contention();
      logic [31:0] got[$], exp[$];
      string nm[$];
      logic [N-1:0] g[5];
      int pix, fp, dc, ns;
      logic [N-1:0] dv, re;
      logic c0, xc, er, be, dt;
      logic [W-1:0] x10;
`ifdef LINE_SCHED_PRIORITY_EN
      g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`else
      g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif
      do_reset();
      set_job(0, 0, 0, 3, 0, 1'b0);
      set_job(1, 0, 0, 0, 5, 1'b1);
      req_valid = 2'b11;
      #1;
      got.push_back(32'(req_ready)); exp.push_back(32'(g[0])); nm.push_back("cont_ready0");
      for (int j = 0; j < 4; j++) begin
         run_job(-1, 2'b00, 2'b00, '0,
                 pix, fp, dc, dv, ns, c0, x10, xc, er, re, be, dt);
         got.push_back(32'(dv)); exp.push_back(32'(g[j])); nm.push_back("cont_done_vec");
         got.push_back(32'(re)); exp.push_back(32'(g[j+1])); nm.push_back("cont_next_ready");
         got.push_back(32'(dc)); exp.push_back((g[j] == 2'b01) ? 6 : 8); nm.push_back("cont_done_cyc");
         got.push_back(32'(er)); exp.push_back(0); nm.push_back("cont_wait_rdy");
      end
      req_valid = '0;
      for (int i = 0; i < got.size(); i++) begin
         vectors++;
         if (got[i] !== exp[i]) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm[i], got[i], exp[i]);
         end
      end
   endtask

   task automatic test_late_stability();
      logic [31:0] got[$], exp[$];
      string nm[$];
      int pix, fp, dc, ns;
      logic [N-1:0] dv, re;
      logic c0, xc, er, be, dt;
      logic [W-1:0] x10;
      do_reset();
      set_job(0, 2, 2, 6, 4, 1'b1);
      set_job(1, 10, 3, 40, 3, 1'b0);
      req_valid = 2'b01;
      #1;
      got.push_back(32'(req_ready)); exp.push_back(1); nm.push_back("late_ready0");
      run_job(3, 2'b01, 2'b10, 11'd40,
              pix, fp, dc, dv, ns, c0, x10, xc, er, re, be, dt);
      got.push_back(32'(er)); exp.push_back(0); nm.push_back("late_no_early");
      got.push_back(32'(re)); exp.push_back(2); nm.push_back("late_ready1");
      got.push_back(32'(dv)); exp.push_back(1); nm.push_back("late_done0");
      got.push_back(32'(dc)); exp.push_back(7); nm.push_back("late_done_cyc");
      got.push_back(32'(pixel_color)); exp.push_back(1); nm.push_back("late_color_idle");
      run_job(5, 2'b10, 2'b00, 11'd50,
              pix, fp, dc, dv, ns, c0, x10, xc, er, re, be, dt);
      got.push_back(32'(c0)); exp.push_back(0); nm.push_back("late_color_new");
      got.push_back(32'(ns)); exp.push_back(1); nm.push_back("late_nstart");
      got.push_back(32'(x10)); exp.push_back(40); nm.push_back("stab_x1_start");
      got.push_back(32'(xc)); exp.push_back(0); nm.push_back("stab_x1_changed");
      got.push_back(32'(drv_x1)); exp.push_back(40); nm.push_back("stab_x1_end");
      got.push_back(32'(drv_x0)); exp.push_back(10); nm.push_back("stab_x0_end");
      got.push_back(32'(pix)); exp.push_back(31); nm.push_back("stab_pixels");
      got.push_back(32'(dv)); exp.push_back(2); nm.push_back("stab_done1");
      got.push_back(32'(dc)); exp.push_back(33); nm.push_back("stab_done_cyc");
      for (int i = 0; i < got.size(); i++) begin
         vectors++;
         if (got[i] !== exp[i]) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm[i], got[i], exp[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] got[$], exp[$];
      string nm[$];
      int pix, fp, dc, ns;
      logic [N-1:0] dv, re;
      logic c0, xc, er, be, dt, dn;
      logic [W-1:0] x10;
      do_reset();
      set_job(0, 0, 0, 20, 0, 1'b1);
      set_job(1, 0, 0, 0, 2, 1'b0);
      req_valid = 2'b01;
      #1;
      got.push_back(32'(req_ready)); exp.push_back(1); nm.push_back("mid_ready0");
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 0) req_valid = '0;
         #1;
      end
      got.push_back(32'(pixel_wr)); exp.push_back(1); nm.push_back("mid_drawing");
      #1;
      reset = 1'b0;
      req_valid = 2'b11;
      #1;
      got.push_back(32'(busy)); exp.push_back(0); nm.push_back("mid_busy");
      got.push_back(32'(pixel_wr)); exp.push_back(0); nm.push_back("mid_pixwr");
      got.push_back(32'(drv_start)); exp.push_back(0); nm.push_back("mid_start");
      got.push_back(32'(pixel_color)); exp.push_back(0); nm.push_back("mid_color");
      got.push_back(32'(drv_x1)); exp.push_back(0); nm.push_back("mid_x1");
      got.push_back(32'(req_ready)); exp.push_back(0); nm.push_back("mid_ready_rst");
      got.push_back(32'(req_done)); exp.push_back(0); nm.push_back("mid_done_rst");
      dn = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (|req_done || busy) dn = 1'b1;
      end
      got.push_back(32'(dn)); exp.push_back(0); nm.push_back("mid_held_quiet");
      @(negedge clk);
      reset = 1'b1;
      #1;
      got.push_back(32'(req_ready)); exp.push_back(1); nm.push_back("mid_rel_ready0");
      run_job(-1, 2'b01, 2'b00, '0,
              pix, fp, dc, dv, ns, c0, x10, xc, er, re, be, dt);
      req_valid = '0;
      got.push_back(32'(dv)); exp.push_back(1); nm.push_back("mid_rel_done0");
      got.push_back(32'(dc)); exp.push_back(23); nm.push_back("mid_rel_done_cyc");
      got.push_back(32'(re)); exp.push_back(2); nm.push_back("mid_rel_ready1");
      for (int i = 0; i < got.size(); i++) begin
         vectors++;
         if (got[i] !== exp[i]) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm[i], got[i], exp[i]);
         end
      end
   endtask

   task automatic test_degenerate();
      logic [31:0] got[$], exp[$];
      string nm[$];
      int pix, fp, dc, ns;
      logic [N-1:0] dv, re;
      logic c0, xc, er, be, dt;
      logic [W-1:0] x10;
      do_reset();
      set_job(0, 7, 7, 7, 7, 1'b1);
      req_valid = 2'b01;
      #1;
      got.push_back(32'(req_ready)); exp.push_back(1); nm.push_back("deg_ready");
      run_job(-1, 2'b01, 2'b00, '0,
              pix, fp, dc, dv, ns, c0, x10, xc, er, re, be, dt);
      got.push_back(32'(pix)); exp.push_back(1); nm.push_back("deg_pixels");
      got.push_back(32'(fp)); exp.push_back(1); nm.push_back("deg_first_pix");
      got.push_back(32'(dc)); exp.push_back(3); nm.push_back("deg_done_cyc");
      got.push_back(32'(dv)); exp.push_back(1); nm.push_back("deg_done_vec");
      got.push_back(32'(be)); exp.push_back(0); nm.push_back("deg_busy_end");
      for (int i = 0; i < got.size(); i++) begin
         vectors++;
         if (got[i] !== exp[i]) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm[i], got[i], exp[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_late_stability();
      test_mid_reset();
      test_degenerate();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
